pwm_decoder: RTL and testbench

Self-test readback block for the ultrasound PWM outputs. It samples all `DEPTH` transducer PWM lines against the shared `TIME_CNT` carrier counter and timestamps the rising and falling edges in each 256-count carrier period. It then reconstructs the per-channel rise time and pulse width and streams them out one channel per cycle. It sits beside `pwm`, taps `PWM_OUT`, and feeds the debug/readback path, so the output of the intensity/phase pipeline can be checked in-system.

---
 rtl/pwm_decoder_if.sv | 37 +++
 rtl/pwm_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_pwm_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if
//   Result stream from the PWM self-test decoder to the debug/readback path.
//   master : driven by pwm_decoder
//   slave  : consumer of the result stream
//   Signals:
//     DOUT_VALID      - a channel result is presented this cycle
//     IDX_OUT         - channel index of the result
//     RISE_OUT        - TIME_CNT value at the last rising edge in the period
//     PULSE_WIDTH_OUT - reconstructed high time in counts, 0..256
//     STATUS_OUT      - 0 OK, 1 constant low, 2 constant high, 3 error
//     ERR_CNT         - saturating count of emitted status-3 results
interface pwm_decoder_if;
    logic        DOUT_VALID;
    logic [7:0]  IDX_OUT;
    logic [7:0]  RISE_OUT;
    logic [8:0]  PULSE_WIDTH_OUT;
    logic [1:0]  STATUS_OUT;
    logic [15:0] ERR_CNT;

    modport master (
        output DOUT_VALID,
        output IDX_OUT,
        output RISE_OUT,
        output PULSE_WIDTH_OUT,
        output STATUS_OUT,
        output ERR_CNT
    );

    modport slave (
        input DOUT_VALID,
        input IDX_OUT,
        input RISE_OUT,
        input PULSE_WIDTH_OUT,
        input STATUS_OUT,
        input ERR_CNT
    );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Self-test readback for the transducer PWM outputs. Every channel's rising
//   and falling edges are timestamped against the shared 256-count carrier
//   counter. At each period end (TIME_CNT == 255) the live edge state is
//   copied to a shadow bank, and the shadow bank is decoded and streamed out
//   one channel per cycle.
//   Ports:
//     CLK        - system clock (same domain as TIME_CNT and PWM_IN)
//     RESET_N    - synchronous active-low reset
//     CAPTURE_EN - enables result streaming; low forces re-arm
//     TIME_CNT   - carrier counter, +1 per cycle, wraps 255 -> 0
//     PWM_IN     - DEPTH PWM lines
//     dout       - result stream (pwm_decoder_if master)
module pwm_decoder #(
    parameter int unsigned DEPTH = 249
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CAPTURE_EN,
    input  logic [7:0]       TIME_CNT,
    input  logic [DEPTH-1:0] PWM_IN,
    pwm_decoder_if.master    dout
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  LAST_IDX = 8'(DEPTH - 1);

    localparam logic [1:0] STS_OK   = 2'd0;
    localparam logic [1:0] STS_LOW  = 2'd1;
    localparam logic [1:0] STS_HIGH = 2'd2;
    localparam logic [1:0] STS_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Live edge capture
    logic [DEPTH-1:0]      prev_q, prev_d;
    logic [DEPTH-1:0][7:0] rise_t_q, rise_t_d;
    logic [DEPTH-1:0][7:0] fall_t_q, fall_t_d;
    logic [DEPTH-1:0]      rise_seen_q, rise_seen_d;
    logic [DEPTH-1:0]      fall_seen_q, fall_seen_d;

    // Shadow bank, loaded at period end
    logic [DEPTH-1:0][7:0] sh_rise_t_q, sh_rise_t_d;
    logic [DEPTH-1:0][7:0] sh_fall_t_q, sh_fall_t_d;
    logic [DEPTH-1:0]      sh_rise_seen_q, sh_rise_seen_d;
    logic [DEPTH-1:0]      sh_fall_seen_q, sh_fall_seen_d;
    logic [DEPTH-1:0]      sh_lvl_q, sh_lvl_d;

    // Drain FSM and registered outputs
    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        dout_valid_q, dout_valid_d;
    logic [7:0]  idx_out_q, idx_out_d;
    logic [7:0]  rise_out_q, rise_out_d;
    logic [8:0]  width_q, width_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic                  period_end;
    logic [DEPTH-1:0]      rise_edge, fall_edge;
    logic [DEPTH-1:0]      live_rise_seen, live_fall_seen;
    logic [DEPTH-1:0][7:0] live_rise_t, live_fall_t;

    assign period_end     = (TIME_CNT == 8'hFF);
    assign rise_edge      = PWM_IN & ~prev_q;
    assign fall_edge      = ~PWM_IN & prev_q;
    assign live_rise_seen = rise_seen_q | rise_edge;
    assign live_fall_seen = fall_seen_q | fall_edge;

    // live_* already include this cycle's edges, so an edge on the period-end
    // cycle lands in the shadow copy while the live flags restart cleared.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live_rise_t[i] = rise_edge[i] ? TIME_CNT : rise_t_q[i];
            live_fall_t[i] = fall_edge[i] ? TIME_CNT : fall_t_q[i];
        end
    end

    always_comb begin
        prev_d         = PWM_IN;
        rise_t_d       = live_rise_t;
        fall_t_d       = live_fall_t;
        rise_seen_d    = period_end ? '0 : live_rise_seen;
        fall_seen_d    = period_end ? '0 : live_fall_seen;
        sh_rise_t_d    = period_end ? live_rise_t    : sh_rise_t_q;
        sh_fall_t_d    = period_end ? live_fall_t    : sh_fall_t_q;
        sh_rise_seen_d = period_end ? live_rise_seen : sh_rise_seen_q;
        sh_fall_seen_d = period_end ? live_fall_seen : sh_fall_seen_q;
        sh_lvl_d       = period_end ? PWM_IN         : sh_lvl_q;
    end

    // Decode of the shadow entry for the channel currently being drained
    logic [IDX_W-1:0] sel;
    logic [7:0]       sel_rise, sel_fall;
    logic             sel_rs, sel_fs, sel_lvl;
    logic [1:0]       dec_status;
    logic [7:0]       dec_rise;
    logic [8:0]       dec_width;

    assign sel      = idx_q[IDX_W-1:0];
    assign sel_rise = sh_rise_t_q[sel];
    assign sel_fall = sh_fall_t_q[sel];
    assign sel_rs   = sh_rise_seen_q[sel];
    assign sel_fs   = sh_fall_seen_q[sel];
    assign sel_lvl  = sh_lvl_q[sel];

    always_comb begin
        dec_status = STS_ERR;
        dec_rise   = '0;
        dec_width  = '0;
        if (sel_rs && sel_fs) begin
            // Modular 8-bit difference handles pulses wrapping the period edge
            dec_status = STS_OK;
            dec_rise   = sel_rise;
            dec_width  = {1'b0, 8'(sel_fall - sel_rise)};
        end else if (!sel_rs && !sel_fs) begin
            if (sel_lvl) begin
                dec_status = STS_HIGH;
                dec_width  = 9'd256;
            end else begin
                dec_status = STS_LOW;
            end
        end else begin
            dec_status = STS_ERR;
            dec_rise   = sel_rs ? sel_rise : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dout_valid_d = 1'b0;
        idx_out_d    = idx_out_q;
        rise_out_d   = rise_out_q;
        width_d      = width_q;
        status_d     = status_q;
        err_cnt_d    = err_cnt_q;
        if (!CAPTURE_EN) begin
            state_d = ST_ARM;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                // First period end after arming covers a partial period
                ST_ARM: if (period_end) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (period_end) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                    end
                end
                ST_DRAIN: begin
                    dout_valid_d = 1'b1;
                    idx_out_d    = idx_q;
                    rise_out_d   = dec_rise;
                    width_d      = dec_width;
                    status_d     = dec_status;
                    if (dec_status == STS_ERR && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_WAIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: state_d = ST_ARM;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            prev_q         <= '0;
            rise_t_q       <= '0;
            fall_t_q       <= '0;
            rise_seen_q    <= '0;
            fall_seen_q    <= '0;
            sh_rise_t_q    <= '0;
            sh_fall_t_q    <= '0;
            sh_rise_seen_q <= '0;
            sh_fall_seen_q <= '0;
            sh_lvl_q       <= '0;
            state_q        <= ST_ARM;
            idx_q          <= '0;
            dout_valid_q   <= 1'b0;
            idx_out_q      <= '0;
            rise_out_q     <= '0;
            width_q        <= '0;
            status_q       <= '0;
            err_cnt_q      <= '0;
        end else begin
            prev_q         <= prev_d;
            rise_t_q       <= rise_t_d;
            fall_t_q       <= fall_t_d;
            rise_seen_q    <= rise_seen_d;
            fall_seen_q    <= fall_seen_d;
            sh_rise_t_q    <= sh_rise_t_d;
            sh_fall_t_q    <= sh_fall_t_d;
            sh_rise_seen_q <= sh_rise_seen_d;
            sh_fall_seen_q <= sh_fall_seen_d;
            sh_lvl_q       <= sh_lvl_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            dout_valid_q   <= dout_valid_d;
            idx_out_q      <= idx_out_d;
            rise_out_q     <= rise_out_d;
            width_q        <= width_d;
            status_q       <= status_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign dout.DOUT_VALID      = dout_valid_q;
    assign dout.IDX_OUT         = idx_out_q;
    assign dout.RISE_OUT        = rise_out_q;
    assign dout.PULSE_WIDTH_OUT = width_q;
    assign dout.STATUS_OUT      = status_q;
    assign dout.ERR_CNT         = err_cnt_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
//   Scoreboard bench for pwm_decoder. The stimulus process drives the carrier
//   counter and per-channel PWM patterns, and at every period end that should
//   produce a stream it queues the hand-computed per-channel results with the
//   cycle each must appear on. A monitor on the falling edge pops and compares.
module tb_pwm_decoder;

    localparam int unsigned DEPTH = 249;

    logic             clk;
    logic             rst_n;
    logic             cap;
    logic [7:0]       tcnt;
    logic [DEPTH-1:0] pwm;

    pwm_decoder_if dout_if ();

    pwm_decoder #(.DEPTH(DEPTH)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .CAPTURE_EN (cap),
        .TIME_CNT   (tcnt),
        .PWM_IN     (pwm),
        .dout       (dout_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  idx;
        logic [7:0]  rise;
        logic [8:0]  width;
        logic [1:0]  status;
        logic [15:0] err;
        bit          opt;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned pnum     = 1;
    int unsigned err_exp  = 0;

    // Channel patterns: 0 high 100..149, 1 wrapped 240..9, 2 const high,
    // 3 const low, 4 rises at 30 in period 3 then stays high, 5 high 0..127,
    // 6 high 200..254 (falls on period-end cycle), 7 high 255..20 (rises on
    // period-end cycle), 8 single-count pulse at 1, 9 two pulses (last wins),
    // others: odd high, even low.
    function automatic logic level(input int unsigned ch, input logic [7:0] t,
                                   input int unsigned p);
        case (ch)
            0: return (t >= 100 && t <= 149);
            1: return (t >= 240 || t <= 9);
            2: return 1'b1;
            3: return 1'b0;
            4: return (p > 3 || (p == 3 && t >= 30));
            5: return (t <= 127);
            6: return (t >= 200 && t <= 254);
            7: return (t == 255 || t <= 20);
            8: return (t == 1);
            9: return ((t >= 10 && t <= 19) || (t >= 50 && t <= 59));
            default: return ((ch % 2) == 1);
        endcase
    endfunction

    task automatic expected(input int unsigned ch, input int unsigned p,
                            output logic [1:0] st, output logic [7:0] r,
                            output logic [8:0] w);
        st = 2'd1; r = 8'd0; w = 9'd0;
        case (ch)
            0: begin st = 2'd0; r = 8'd100; w = 9'd50;  end
            1: begin st = 2'd0; r = 8'd240; w = 9'd26;  end
            2: begin st = 2'd2; w = 9'd256; end
            3: begin st = 2'd1; end
            4: begin
                if (p < 3)       st = 2'd1;
                else if (p == 3) begin st = 2'd3; r = 8'd30; end
                else             begin st = 2'd2; w = 9'd256; end
            end
            5: begin st = 2'd0; r = 8'd0;   w = 9'd128; end
            6: begin st = 2'd0; r = 8'd200; w = 9'd55;  end
            7: begin st = 2'd0; r = 8'd255; w = 9'd22;  end
            8: begin st = 2'd0; r = 8'd1;   w = 9'd1;   end
            9: begin st = 2'd0; r = 8'd50;  w = 9'd10;  end
            default: begin
                if ((ch % 2) == 1) begin st = 2'd2; w = 9'd256; end
                else st = 2'd1;
            end
        endcase
    endtask

    task automatic drive_pwm();
        for (int unsigned i = 0; i < DEPTH; i++) pwm[i] = level(i, tcnt, pnum);
    endtask

    task automatic tick();
        @(negedge clk);
        tcnt = tcnt + 8'd1;
        if (tcnt == 8'd0) pnum++;
        drive_pwm();
    endtask

    // Advance to the period-end cycle, then queue nreq required results and
    // nopt optional ones (a drain aborted by CAPTURE_EN may emit one more).
    task automatic run_to_end(input int unsigned nreq, input int unsigned nopt);
        exp_t e;
        do tick(); while (tcnt != 8'hFF);
        for (int unsigned k = 0; k < nreq + nopt; k++) begin
            expected(k, pnum, e.status, e.rise, e.width);
            e.cyc = cyc + 2 + k;
            e.idx = 8'(k);
            e.opt = (k >= nreq);
            if (e.status == 2'd3 && !e.opt) err_exp++;
            e.err = 16'(err_exp);
            q.push_back(e);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"}, 32'(dout_if.DOUT_VALID), 32'd0);
        check_val({tag, "_idx"},   32'(dout_if.IDX_OUT), 32'd0);
        check_val({tag, "_rise"},  32'(dout_if.RISE_OUT), 32'd0);
        check_val({tag, "_width"}, 32'(dout_if.PULSE_WIDTH_OUT), 32'd0);
        check_val({tag, "_status"},32'(dout_if.STATUS_OUT), 32'd0);
        check_val({tag, "_errcnt"},32'(dout_if.ERR_CNT), 32'd0);
    endtask

    // Monitor
    exp_t m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            if (!q[0].opt) begin
                checks++;
                failures++;
                $display("FAIL missing_result idx=%0d due_cycle=%0d actual=no_valid required=valid",
                         q[0].idx, q[0].cyc);
            end
            void'(q.pop_front());
        end
        if (dout_if.DOUT_VALID === 1'b1) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_valid cycle=%0d actual idx=%0d required=no_valid",
                         cyc, dout_if.IDX_OUT);
            end else begin
                m = q.pop_front();
                if (dout_if.IDX_OUT !== m.idx || dout_if.RISE_OUT !== m.rise ||
                    dout_if.PULSE_WIDTH_OUT !== m.width || dout_if.STATUS_OUT !== m.status ||
                    dout_if.ERR_CNT !== m.err) begin
                    failures++;
                    $display("FAIL stream cycle=%0d actual idx=%0d rise=%0d width=%0d status=%0d err=%0d required idx=%0d rise=%0d width=%0d status=%0d err=%0d",
                             cyc, dout_if.IDX_OUT, dout_if.RISE_OUT, dout_if.PULSE_WIDTH_OUT,
                             dout_if.STATUS_OUT, dout_if.ERR_CNT,
                             m.idx, m.rise, m.width, m.status, m.err);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cap   = 1'b1;
        tcnt  = 8'd0;
        drive_pwm();

        repeat (4) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_to_end(0, 0);                  // period 1: partial, discarded
        repeat (3) run_to_end(DEPTH, 0);   // periods 2..4

        // Period 5: drop CAPTURE_EN as idx 10 would be emitted
        run_to_end(10, 1);
        repeat (11) tick();
        cap = 1'b0;
        repeat (2) tick();
        check_val("cap_drop_valid", 32'(dout_if.DOUT_VALID), 32'd0);
        repeat (20) tick();
        cap = 1'b1;

        run_to_end(0, 0);                  // period 6: discarded after re-arm
        run_to_end(DEPTH, 0);              // period 7: full stream

        // Period 8: reset after idx 4 has been presented
        run_to_end(5, 0);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check_outputs_zero("midreset");
        rst_n   = 1'b1;
        err_exp = 0;

        run_to_end(0, 0);                  // period 9: discarded after reset
        run_to_end(DEPTH, 0);              // period 10: full stream
        repeat (DEPTH + 8) tick();

        check_val("leftover_required", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
